cic_out_quant: RTL and testbench

Output quantizer and elastic buffer placed directly after the full-precision CIC interpolator. It takes the wide CIC result and its validation strobe and removes the filter gain with a round-half-up arithmetic shift. It then saturates the result to the DAC/downstream word width and queues it in a small FIFO with a valid/ready handshake toward the consumer. Clipping and overflow events are reported through sticky flags and a counter.

---
 rtl/cic_out_quant.sv | 112 +++++++++++
 tb/tb_cic_out_quant.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_out_quant.sv
// Output quantizer for the CIC interpolator: round-half-up shift, clip or wrap, then elastic FIFO.
// Define CIC_OQ_SAT_EN for saturation with live ovf_flag/sat_cnt; without it the result wraps.
module cic_out_quant #(
    parameter int Win   = 38,
    parameter int Wout  = 16,
    parameter int SHIFT = 22,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic signed [Win-1:0]  i_data,
    input  logic                   val_in,
    input  logic                   rdy_in,
    output logic signed [Wout-1:0] o_data,
    output logic                   val_out,
    output logic                   ovf_flag,
    output logic                   drop_flag,
    output logic [15:0]            sat_cnt
);
    localparam int STAGES  = 2;
    localparam int AW      = $clog2(DEPTH);
    localparam int RND_POS = (SHIFT == 0) ? 0 : SHIFT - 1;
    localparam logic signed [Win:0] RND = (SHIFT == 0) ? '0 : ((Win+1)'(1) << RND_POS);

    logic [STAGES:1]      vld_pipe;
    logic signed [Win:0]  r1;
    logic [Wout-1:0]      s2_data;

    always_ff @(posedge clk) begin
        if (rst) vld_pipe <= '0;
        else     vld_pipe <= {vld_pipe[STAGES-1:1], val_in};
    end

    // One guard bit above the input so adding the half-LSB term never overflows.
    always_ff @(posedge clk) begin
        r1 <= $signed({i_data[Win-1], i_data}) + RND;
    end

`ifdef CIC_OQ_SAT_EN
    localparam logic signed [Win:0] QMAX = (Win+1)'((longint'(1) <<< (Wout-1)) - 1);
    localparam logic signed [Win:0] QMIN = ~QMAX;

    logic signed [Win:0] q;
    logic                clip_hi, clip_lo, s2_clip;

    assign q       = r1 >>> SHIFT;
    assign clip_hi = q > QMAX;
    assign clip_lo = q < QMIN;

    always_ff @(posedge clk) begin
        if (clip_hi)      s2_data <= {1'b0, {(Wout-1){1'b1}}};
        else if (clip_lo) s2_data <= {1'b1, {(Wout-1){1'b0}}};
        else              s2_data <= q[Wout-1:0];
        s2_clip <= clip_hi | clip_lo;
    end
`else
    always_ff @(posedge clk) begin
        s2_data <= Wout'(r1 >>> SHIFT);
    end
`endif

    logic [Wout-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic            full, rd, wr, drop;

    assign val_out = (count != '0);
    assign o_data  = val_out ? mem[rd_ptr] : '0;
    assign full    = (count == (AW+1)'(DEPTH));
    assign rd      = val_out & rdy_in;
    // A read in the same cycle frees the slot, so a full FIFO still accepts.
    assign wr      = vld_pipe[STAGES] & (~full | rd);
    assign drop    = vld_pipe[STAGES] & full & ~rd;

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= s2_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            drop_flag <= 1'b0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + AW'(1);
            if (rd) rd_ptr <= rd_ptr + AW'(1);
            case ({wr, rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (drop) drop_flag <= 1'b1;
        end
    end

`ifdef CIC_OQ_SAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_flag <= 1'b0;
            sat_cnt  <= '0;
        end else if (vld_pipe[STAGES] & s2_clip) begin
            ovf_flag <= 1'b1;
            if (sat_cnt != 16'hFFFF) sat_cnt <= sat_cnt + 16'd1;
        end
    end
`else
    assign ovf_flag = 1'b0;
    assign sat_cnt  = '0;
`endif

endmodule

// File: tb/tb_cic_out_quant.sv
// Randomized bench for cic_out_quant against a queue-based reference model, plus directed literal checks.
module tb_cic_out_quant;
    logic                clk = 1'b0;
    logic                rst;
    logic signed [37:0]  i_data;
    logic                val_in, rdy_in;
    logic signed [15:0]  o_data;
    logic                val_out, ovf_flag, drop_flag;
    logic [15:0]         sat_cnt;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    cic_out_quant dut (
        .clk(clk), .rst(rst), .i_data(i_data), .val_in(val_in), .rdy_in(rdy_in),
        .o_data(o_data), .val_out(val_out), .ovf_flag(ovf_flag),
        .drop_flag(drop_flag), .sat_cnt(sat_cnt)
    );

    // Unbounded quotient: floor((x + 2^21) / 2^22).
    function automatic longint raw_q(longint x);
        return (x + (longint'(1) <<< 21)) >>> 22;
    endfunction

    function automatic bit clips(longint x);
        longint q = raw_q(x);
        return (q > 32767) || (q < -32768);
    endfunction

    function automatic longint quant(longint x);
        longint q = raw_q(x);
        logic signed [15:0] w;
`ifdef CIC_OQ_SAT_EN
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
        return q;
`else
        w = q[15:0];
        return longint'(w);
`endif
    endfunction

    // Reference: a 2-cycle delay line feeding an 8-entry queue.
    longint fq[$];
    bit     p1v = 0, p2v = 0;
    longint p1x = 0, p2x = 0;
    bit     m_ovf = 0, m_drop = 0;
    int     m_sat = 0;

    always @(posedge clk) begin
        bit rd;
        if (rst) begin
            fq.delete();
            p1v = 0; p2v = 0;
            m_ovf = 0; m_drop = 0; m_sat = 0;
        end else begin
            rd = (fq.size() > 0) && rdy_in;
            if (rd) void'(fq.pop_front());
            if (p2v) begin
                if (fq.size() < 8) fq.push_back(quant(p2x));
                else m_drop = 1;
`ifdef CIC_OQ_SAT_EN
                if (clips(p2x)) begin
                    m_ovf = 1;
                    if (m_sat < 65535) m_sat++;
                end
`endif
            end
            p2v = p1v; p2x = p1x;
            p1v = val_in; p1x = longint'(i_data);
        end
    end

    task automatic chk(string nm, longint act, longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_val_out", longint'(val_out), longint'(fq.size() > 0));
            chk("m_o_data", longint'(o_data), (fq.size() > 0) ? fq[0] : 0);
            chk("m_ovf", longint'(ovf_flag), longint'(m_ovf));
            chk("m_drop", longint'(drop_flag), longint'(m_drop));
            chk("m_sat_cnt", longint'(sat_cnt), longint'(m_sat));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit v, longint x);
        val_in = v;
        i_data = x[37:0];
    endtask

    task automatic do_reset();
        drive(0, 0);
        rst = 1;
        tick();
        rst = 0;
    endtask

    // Single sample with rdy_in=1: appears after the third edge, gone after the fourth.
    task automatic one(string nm, longint x, longint e);
        drive(1, x);
        tick();
        drive(0, 0);
        tick();
        tick();
        chk({nm, "_val"}, longint'(val_out), 1);
        chk(nm, longint'(o_data), e);
        tick();
        chk({nm, "_once"}, longint'(val_out), 0);
    endtask

    initial begin
        longint big;
        logic [37:0] b;
        rst = 1; rdy_in = 1;
        drive(0, 0);
        tick();
        tick();
        rst = 0;
        chk_en = 1;
        chk("rst_val_out", longint'(val_out), 0);
        chk("rst_o_data", longint'(o_data), 0);
        chk("rst_ovf", longint'(ovf_flag), 0);
        chk("rst_drop", longint'(drop_flag), 0);
        chk("rst_sat", longint'(sat_cnt), 0);

        // Basic path with latency check
        drive(1, 5 * (longint'(1) <<< 22));
        tick();
        drive(0, 0);
        tick();
        chk("basic_early", longint'(val_out), 0);
        tick();
        chk("basic_val", longint'(val_out), 1);
        chk("basic_data", longint'(o_data), 5);
        tick();
        chk("basic_once", longint'(val_out), 0);

        // Rounding boundaries
        one("rnd_half_pos", (longint'(1) <<< 21), 1);
        one("rnd_below_half", (longint'(1) <<< 21) - 1, 0);
        one("rnd_half_neg", -(longint'(1) <<< 21), 0);
        one("rnd_below_neg", -(longint'(1) <<< 21) - 1, -1);

        // Extremes: only the positive end can exceed the output range after rounding
        big = (longint'(1) <<< 37);
`ifdef CIC_OQ_SAT_EN
        one("sat_hi", big - 1, 32767);
        chk("sat_hi_ovf", longint'(ovf_flag), 1);
        chk("sat_hi_cnt", longint'(sat_cnt), 1);
        one("sat_lo", -big, -32768);
        chk("sat_lo_cnt", longint'(sat_cnt), 1);
`else
        one("wrap_hi", big - 1, -32768);
        one("wrap_lo", -big, -32768);
        chk("wrap_ovf", longint'(ovf_flag), 0);
        chk("wrap_cnt", longint'(sat_cnt), 0);
`endif

        // Full FIFO with simultaneous read and write: nothing dropped
        do_reset();
        for (int i = 1; i <= 30; i++) begin
            drive(1, longint'(i) <<< 22);
            rdy_in = (i >= 11);
            tick();
        end
        drive(0, 0);
        rdy_in = 1;
        repeat (12) tick();
        chk("full_rw_drop", longint'(drop_flag), 0);
        chk("full_rw_empty", longint'(val_out), 0);

        // Backpressure: samples 9 and 10 are dropped
        do_reset();
        rdy_in = 0;
        for (int i = 1; i <= 10; i++) begin
            drive(1, longint'(i) <<< 22);
            tick();
        end
        drive(0, 0);
        tick();
        tick();
        chk("bp_drop", longint'(drop_flag), 1);
        chk("bp_val", longint'(val_out), 1);
        rdy_in = 1;
        for (int i = 1; i <= 8; i++) begin
            chk("bp_order", longint'(o_data), longint'(i));
            tick();
        end
        chk("bp_empty", longint'(val_out), 0);

        // Reset with 5 buffered and 2 in flight
        do_reset();
        rdy_in = 0;
        for (int i = 1; i <= 7; i++) begin
            drive(1, longint'(i + 100) <<< 22);
            tick();
        end
        drive(0, 0);
        rst = 1;
        tick();
        rst = 0;
        chk("mid_rst_val", longint'(val_out), 0);
        chk("mid_rst_data", longint'(o_data), 0);
        chk("mid_rst_ovf", longint'(ovf_flag), 0);
        chk("mid_rst_drop", longint'(drop_flag), 0);
        chk("mid_rst_sat", longint'(sat_cnt), 0);
        rdy_in = 1;
        repeat (5) tick();
        chk("mid_rst_quiet", longint'(val_out), 0);

        // Random traffic with varying downstream pressure and occasional resets
        for (int c = 0; c < 4000; c++) begin
            int dens;
            dens = ((c / 250) % 4);
            b = 38'({$urandom(), $urandom()});
            big = longint'($signed(b)) >>> $urandom_range(0, 22);
            drive($urandom_range(0, 3) != 0, big);
            rdy_in = (dens == 0) ? 1'b1 : ($urandom_range(0, dens) == 0);
            rst = ($urandom_range(0, 599) == 0);
            tick();
        end
        rst = 0;
        drive(0, 0);
        rdy_in = 1;
        repeat (12) tick();
        chk("final_drain", longint'(val_out), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
